// File: rtl/tinybf_pkg.sv
// -----------------------------------------------------------------------------
// tinybf_pkg
// Definitions shared by the TinyBF program loader and its UART receiver:
//   - RX FSM state encodings (RX_IDLE .. RX_BREAK)
//   - loader FSM state encodings (L_IDLE, L_LOAD, L_DONE)
//   - default UART bit period in clk cycles
//   - instruction field widths (3-bit opcode, 5-bit operand) of the byte
//     written into program memory
// -----------------------------------------------------------------------------
package tinybf_pkg;

  // UART receiver states
  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

  // Program loader states
  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_LOAD = 2'd1,
    L_DONE = 2'd2
  } ld_state_e;

  // Default clk cycles per UART bit
  localparam int unsigned CLKS_PER_BIT_DEF = 32'd16;

  // Instruction layout: {opcode[2:0], operand[4:0]}
  localparam int unsigned OPCODE_W  = 32'd3;
  localparam int unsigned OPERAND_W = 32'd5;
  localparam int unsigned INSTR_W   = OPCODE_W + OPERAND_W;

  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic [OPERAND_W-1:0] operand;
  } instr_t;

endpackage : tinybf_pkg

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver: 2-flop synchronizer, start-bit qualification at the bit
// centre, LSB-first data sampling, stop-bit check and break recovery.
//
// Ports:
//   clk_i         system clock
//   rst_i         asynchronous active-low reset
//   rx_i          asynchronous serial line, idle high
//   byte_o        last correctly framed byte
//   byte_valid_o  one-cycle pulse when byte_o is updated
//   frame_err_o   one-cycle pulse when a stop bit is sampled low
// -----------------------------------------------------------------------------
module uart_rx
  import tinybf_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  // Half a bit minus one lands the start-bit sample in the middle of the bit
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             meta_r;
  logic             sync_r;
  logic             prev_r;
  rx_state_e        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic [7:0]       byte_r;
  logic             valid_r;
  logic             ferr_r;

  // Line synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
      prev_r <= 1'b1;
    end else begin
      meta_r <= rx_i;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  // Receive state machine with bit-period counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r   <= RX_IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      byte_r    <= 8'h00;
      valid_r   <= 1'b0;
      ferr_r    <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      case (state_r)
        RX_IDLE: begin
          if (prev_r && !sync_r) begin
            state_r <= RX_START;
            cnt_r   <= HALF_RELOAD;
          end
        end
        RX_START: begin
          if (cnt_r == CNT_ZERO) begin
            if (!sync_r) begin
              state_r   <= RX_DATA;
              cnt_r     <= FULL_RELOAD;
              bit_idx_r <= 3'd0;
            end else begin
              // Line went back high before mid-start: treat as a glitch
              state_r <= RX_IDLE;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        RX_DATA: begin
          if (cnt_r == CNT_ZERO) begin
            shift_r <= {sync_r, shift_r[7:1]};
            cnt_r   <= FULL_RELOAD;
            if (bit_idx_r == 3'd7) begin
              state_r <= RX_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        RX_STOP: begin
          if (cnt_r == CNT_ZERO) begin
            if (sync_r) begin
              byte_r  <= shift_r;
              valid_r <= 1'b1;
              state_r <= RX_IDLE;
            end else begin
              // Low stop bit: drop the byte and wait for the line to recover
              ferr_r  <= 1'b1;
              state_r <= RX_BREAK;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        RX_BREAK: begin
          if (sync_r) begin
            state_r <= RX_IDLE;
          end
        end
        default: begin
          state_r <= RX_IDLE;
        end
      endcase
    end
  end

  assign byte_o       = byte_r;
  assign byte_valid_o = valid_r;
  assign frame_err_o  = ferr_r;

endmodule : uart_rx

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Serial program loader for TinyBF. Bytes received over an 8N1 UART are
// written to consecutive program-memory addresses 0..DEPTH-1 while load_en_i
// is high. busy_o holds the core idle during loading; done_o reports a
// complete image.
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-low reset
//   load_en_i    level: 1 = loading enabled, 0 = abort / idle
//   rx_i         UART line, idle high
//   wen_o        single-cycle program-memory write strobe
//   waddr_o      write address (held between writes)
//   wdata_o      instruction byte {opcode[2:0], operand[4:0]} (held)
//   busy_o       high while loading
//   done_o       high once DEPTH bytes were written, until the next load
//   frame_err_o  sticky: a framing error was seen during the current load
// -----------------------------------------------------------------------------
module prog_loader
  import tinybf_pkg::*;
#(
  parameter int unsigned DEPTH        = 32'd16,
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     load_en_i,
  input  logic                     rx_i,
  output logic                     wen_o,
  output logic [$clog2(DEPTH)-1:0] waddr_o,
  output logic [INSTR_W-1:0]       wdata_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     frame_err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_ZERO = AW'(0);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  logic [7:0]         rx_byte_s;
  logic               rx_valid_s;
  logic               rx_ferr_s;

  ld_state_e          lstate_r;
  logic [AW-1:0]      addr_r;
  logic               wen_r;
  logic [AW-1:0]      waddr_r;
  logic [INSTR_W-1:0] wdata_r;
  logic               busy_r;
  logic               done_r;
  logic               ferr_r;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_rx (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rx_i         (rx_i),
    .byte_o       (rx_byte_s),
    .byte_valid_o (rx_valid_s),
    .frame_err_o  (rx_ferr_s)
  );

  // Loader state machine with registered memory-write and status outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lstate_r <= L_IDLE;
      addr_r   <= ADDR_ZERO;
      wen_r    <= 1'b0;
      waddr_r  <= ADDR_ZERO;
      wdata_r  <= {INSTR_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      ferr_r   <= 1'b0;
    end else begin
      wen_r <= 1'b0;
      case (lstate_r)
        L_IDLE: begin
          busy_r <= 1'b0;
          if (load_en_i) begin
            lstate_r <= L_LOAD;
            addr_r   <= ADDR_ZERO;
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
            ferr_r   <= 1'b0;
          end
        end
        L_LOAD: begin
          if (rx_ferr_s) begin
            ferr_r <= 1'b1;
          end
          if (!load_en_i) begin
            // Abort: any byte arriving in this cycle is dropped
            lstate_r <= L_IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
          end else if (rx_valid_s) begin
            wen_r   <= 1'b1;
            waddr_r <= addr_r;
            wdata_r <= rx_byte_s;
            addr_r  <= addr_r + ADDR_ONE;
            // Last slot: leave LOAD together with the final strobe so the
            // address counter never wraps inside one image
            if (addr_r == LAST_ADDR) begin
              lstate_r <= L_DONE;
            end
          end
        end
        L_DONE: begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
          if (!load_en_i) begin
            lstate_r <= L_IDLE;
          end
        end
        default: begin
          lstate_r <= L_IDLE;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign wen_o       = wen_r;
  assign waddr_o     = waddr_r;
  assign wdata_o     = wdata_r;
  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign frame_err_o = ferr_r;

endmodule : prog_loader

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Serial program loader that sits directly upstream of the TinyBF program memory and drives that memory's write port.
- Receives 8N1 UART bytes on a single pin and writes them to sequential program addresses 0..DEPTH-1.
- Signals busy while loading so the top level can hold the CPU core idle, and signals done when the full program image has been written.

Parameters:
- DEPTH, 16, program memory depth in instructions; power of 2; sets waddr_o width.
- CLKS_PER_BIT, 16, clk_i cycles per UART bit; minimum 4; even; CLKS_PER_BIT*9 must exceed DEPTH.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; asynchronous, active-low
- load_en_i  in  1  level; 1 = loading enabled, 0 = abort or idle
- rx_i  in  1  asynchronous UART line; idle high
- wen_o  out  1  single-cycle write strobe to program memory
- waddr_o  out  $clog2(DEPTH)  write address
- wdata_o  out  8  instruction byte (3-bit opcode, 5-bit operand)
- busy_o  out  1  high while in LOAD
- done_o  out  1  high once DEPTH bytes have been written
- frame_err_o  out  1  sticky framing-error flag

Behaviour:
- Reset (rst_i=0, asynchronous): wen_o, waddr_o, wdata_o, busy_o, done_o and frame_err_o all go to 0. Both rx synchronizer flops reset to 1. RX FSM goes to RX_IDLE; loader FSM goes to L_IDLE; all counters go to 0.
- rx_i passes through a 2-flop synchronizer. All RX decisions use the synchronized value.

RX FSM:
- RX_IDLE: a synchronized 1->0 transition moves to RX_START and loads the bit counter with CLKS_PER_BIT/2-1.
- RX_START: when the counter expires, sample the line.
  - 0 -> RX_DATA.
  - 1 -> glitch; return to RX_IDLE with no byte produced.
- RX_DATA: sample every CLKS_PER_BIT cycles (bit centres), 8 bits, LSB first, shifted into the byte register. After bit 7 -> RX_STOP.
- RX_STOP: sample after CLKS_PER_BIT cycles.
  - 1 -> one-cycle byte_valid pulse, then RX_IDLE.
  - 0 -> byte discarded; frame_err_o set to 1 only if the loader is in L_LOAD; move to RX_BREAK.
- RX_BREAK: wait for a synchronized 1, then RX_IDLE.

Loader FSM:
- L_IDLE: busy_o=0. When load_en_i=1: go to L_LOAD, address counter := 0, done_o := 0, frame_err_o := 0.
- L_LOAD: busy_o=1.
  - On byte_valid: in the next cycle wen_o=1 for exactly one cycle, waddr_o=addr, wdata_o=byte; addr increments.
  - If the written address was DEPTH-1, enter L_DONE in the same cycle wen_o is high. busy_o drops and done_o rises on the following edge.
- L_DONE: busy_o=0, done_o=1. Stays until load_en_i=0, then L_IDLE. done_o is held at 1 until the next L_LOAD entry.
- Abort: load_en_i=0 while in L_LOAD goes to L_IDLE on the next edge. busy_o=0, done_o=0. Bytes already written stay in memory. A pending byte_valid in that same cycle is dropped.
- byte_valid in L_IDLE or L_DONE: byte is discarded, no wen_o.
- waddr_o and wdata_o hold their last values when wen_o=0.
- Latency: wen_o asserts 2 cycles after the stop-bit sample edge (one cycle for byte_valid, one for the write register).
- Program memory ignores writes during its DEPTH-cycle post-reset init. The CLKS_PER_BIT*9 > DEPTH constraint guarantees the first write lands after init, even with load_en_i tied high out of reset.
- Address counter never wraps inside a load: L_DONE is entered at DEPTH-1.
- A start bit arriving while the RX FSM is busy is not a special case; bytes are strictly sequential.

Decomposition:
- Shared package tinybf_pkg holds:
  - RX state encodings: RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK.
  - Loader state encodings: L_IDLE, L_LOAD, L_DONE.
  - Default CLKS_PER_BIT.
  - Opcode field widths (3/5) for wdata_o documentation.
- One sub-module, uart_rx: synchronizer, RX FSM and bit counter. It outputs byte_o[7:0], byte_valid_o and frame_err_o (pulse). prog_loader instantiates it and holds the loader FSM, address counter and output registers.

Test Plan:
- Reset: hold rst_i=0 with rx_i=1 -> all outputs 0. Assert rst_i=0 mid-byte -> outputs 0 immediately. After release, the next clean byte is received correctly.
- Full load: CLKS_PER_BIT=16, load_en_i=1, send 16 bytes 0x45,0x80,0x01,0x43,0x80,0xFB,0x00 x10 -> 16 wen_o pulses at waddr 0..15 with matching data. Each wen_o is 2 cycles after its stop sample. busy_o 1->0 and done_o 0->1 one edge after the addr-15 pulse.
- Framing error: in L_LOAD send 0xA5 with stop bit 0 -> no wen_o, frame_err_o=1, addr unchanged. Next good byte 0x3C is written to the same addr.
- Glitch: drive rx_i low for 4 cycles, then high -> no byte_valid, no wen_o, RX returns to idle.
- Abort/restart: drop load_en_i after 5 bytes -> busy_o=0, done_o=0, no further writes. Reassert and send 0x11 -> written to waddr 0.
- Idle discard: load_en_i=0, send 0x7E -> no wen_o, frame_err_o stays 0.
